// File: rtl/cic_up_s4.sv
// cic_up_s4 : two-stage CIC interpolator (2 combs at the input rate,
// zero-stuffing by FACTOR, 2 integrators at the output rate).
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset (priority over clk_enable)
//   clk_enable  high-rate clock enable; all state frozen when low
//   filter_in   signed input sample, captured on edges where ce_in is high
//   ce_in       input request strobe, one per FACTOR enabled clocks
//   filter_out  signed interpolated output (integrator 2 register)
//   ce_out      registered clk_enable; marks a freshly updated filter_out
//
// All arithmetic is modular at OUTPUT_WIDTH bits. Integrator overflow is
// expected and cancels against the combs, so nothing saturates.

module cic_up_s4 #(
   parameter int FACTOR       = 10,
   parameter int INPUT_WIDTH  = 12,
   parameter int OUTPUT_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clk_enable,
   input  logic signed [INPUT_WIDTH-1:0]  filter_in,
   output logic                           ce_in,
   output logic signed [OUTPUT_WIDTH-1:0] filter_out,
   output logic                           ce_out
);

   localparam int          OW         = OUTPUT_WIDTH;
   localparam int          IW         = INPUT_WIDTH;
   localparam logic [15:0] LAST_PHASE = 16'(FACTOR - 1);

   // Add/subtract one bit wider than the datapath, then keep the low OW bits.
   function automatic logic signed [OW-1:0] add_w(input logic signed [OW-1:0] a,
                                                  input logic signed [OW-1:0] b);
      logic signed [OW:0] s;
      s = {a[OW-1], a} + {b[OW-1], b};
      return s[OW-1:0];
   endfunction

   function automatic logic signed [OW-1:0] sub_w(input logic signed [OW-1:0] a,
                                                  input logic signed [OW-1:0] b);
      logic signed [OW:0] s;
      s = {a[OW-1], a} - {b[OW-1], b};
      return s[OW-1:0];
   endfunction

   logic        [15:0]   cur_count;
   logic                 phase_zero;
   logic                 phase_one;
   logic signed [OW-1:0] in_ext;
   logic signed [OW-1:0] in_reg;
   logic signed [OW-1:0] diff1;
   logic signed [OW-1:0] diff2;
   logic signed [OW-1:0] c1;
   logic signed [OW-1:0] c2;
   logic signed [OW-1:0] u;
   logic signed [OW-1:0] int1;
   logic signed [OW-1:0] int2;

   assign phase_zero = (cur_count == 16'd0);
   assign phase_one  = (cur_count == 16'd1);

   // cur_count already sits at 0 while reset is held; masking with reset
   // keeps the request strobe quiet until the first real enabled cycle.
   assign ce_in = clk_enable & phase_zero & ~reset;

   assign in_ext = {{(OW-IW){filter_in[IW-1]}}, filter_in};

   // Comb sections run at the input rate and are evaluated from registers.
   assign c1 = sub_w(in_reg, diff1);
   assign c2 = sub_w(c1, diff2);

   // The comb result is injected exactly once per input period, in the
   // cycle right after the capture, giving the 2-edge input-to-output latency.
   assign u = phase_one ? c2 : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_count <= 16'd0;
         in_reg    <= '0;
         diff1     <= '0;
         diff2     <= '0;
         int1      <= '0;
         int2      <= '0;
         ce_out    <= 1'b0;
      end else begin
         ce_out <= clk_enable;
         if (clk_enable) begin
            if (cur_count == LAST_PHASE) begin
               cur_count <= 16'd0;
            end else begin
               cur_count <= 16'(cur_count + 16'd1);
            end
            if (phase_zero) begin
               in_reg <= in_ext;
               diff1  <= in_reg;
               diff2  <= c1;
            end
            int1 <= add_w(int1, u);
            int2 <= add_w(int2, int1);
         end
      end
   end

   assign filter_out = int2;

endmodule
